sdram_init_seq: RTL and testbench



---
 rtl/sdram_init_seq_if.sv | 27 ++
 rtl/sdram_init_seq.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sdram_init_seq_if.sv
// SDRAM command bus plus the refresh request/grant handshake between the
// init/refresh sequencer (master) and the main memory controller (slave).
interface sdram_init_seq_if;
    logic        sdr_cs_n;
    logic        sdr_ras_n;
    logic        sdr_cas_n;
    logic        sdr_we_n;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        sdr_init_done;
    logic        ref_gnt;
    logic        ref_req;
    logic        ref_busy;
    logic        ref_miss;

    modport master (
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
        output sdr_init_done, ref_req, ref_busy, ref_miss,
        input  ref_gnt
    );

    modport slave (
        input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
        input  sdr_init_done, ref_req, ref_busy, ref_miss,
        output ref_gnt
    );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer (NOP wait, PRECHARGE ALL, N_REF x AUTO REFRESH, LMR).
// Define SDR_INIT_PERIODIC_REF_EN to add periodic refresh with a req/gnt handshake.
module sdram_init_seq #(
    parameter int          T_PWRUP  = 505,
    parameter int          T_RP     = 2,
    parameter int          T_RFC    = 7,
    parameter int          N_REF    = 2,
    parameter int          T_MRD    = 8,
    parameter logic [12:0] MODE_REG = 13'h033,
    parameter int          T_REFI   = 390
) (
    input  logic             clk,
    input  logic             reset,
    sdram_init_seq_if.master bus
);
    localparam int MAX_0 = (T_PWRUP > T_RP) ? T_PWRUP : T_RP;
    localparam int MAX_1 = (MAX_0 > T_RFC) ? MAX_0 : T_RFC;
    localparam int MAX_2 = (MAX_1 > T_MRD) ? MAX_1 : T_MRD;
    localparam int T_MAX = (MAX_2 > T_REFI) ? MAX_2 : T_REFI;
    localparam int CNT_W = $clog2(T_MAX) + 1;
    localparam int REF_W = $clog2(N_REF) + 1;

    localparam logic [3:0]  CMD_NOP = 4'b1111;
    localparam logic [3:0]  CMD_PRE = 4'b0010;
    localparam logic [3:0]  CMD_REF = 4'b0001;
    localparam logic [3:0]  CMD_LMR = 4'b0000;
    localparam logic [12:0] ADDR_ALL_BANKS = 13'h0400;

    typedef enum logic [3:0] {
        S_PWRUP, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC, S_LMR, S_WAIT_MRD, S_DONE,
        S_P_PRE, S_P_WAIT_RP, S_P_REF, S_P_WAIT_RFC
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [REF_W-1:0] ref_cnt;
    logic [3:0]       cmd;
    logic [12:0]      addr;
    logic             init_done;
    logic             cnt_last;

    // Every wait is loaded with its cycle count and ends when it reaches 1,
    // so the following command appears exactly that many cycles later.
    assign cnt_last = (cnt == CNT_W'(1));

`ifdef SDR_INIT_PERIODIC_REF_EN
    logic [CNT_W-1:0] icnt;
    logic             req;
    logic             busy;
    logic             miss;
    logic             gnt_seen;
    logic             expire;
    logic             req_clr;

    assign expire  = init_done && (icnt == CNT_W'(1));
    assign req_clr = (state == S_DONE) && gnt_seen;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_PWRUP;
            cnt       <= CNT_W'(T_PWRUP);
            ref_cnt   <= REF_W'(N_REF);
            cmd       <= CMD_NOP;
            addr      <= '0;
            init_done <= 1'b0;
`ifdef SDR_INIT_PERIODIC_REF_EN
            busy      <= 1'b0;
            gnt_seen  <= 1'b0;
`endif
        end else begin
            cmd  <= CMD_NOP;
            addr <= '0;
            case (state)
                S_PWRUP: begin
                    if (cnt_last) begin
                        state <= S_PRE;
                        cmd   <= CMD_PRE;
                        addr  <= ADDR_ALL_BANKS;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_PRE: begin
                    state <= S_WAIT_RP;
                    cnt   <= CNT_W'(T_RP);
                end
                S_WAIT_RP: begin
                    if (cnt_last) begin
                        state   <= S_REF;
                        cmd     <= CMD_REF;
                        ref_cnt <= ref_cnt - REF_W'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_REF: begin
                    state <= S_WAIT_RFC;
                    cnt   <= CNT_W'(T_RFC);
                end
                S_WAIT_RFC: begin
                    if (cnt_last) begin
                        if (ref_cnt != '0) begin
                            state   <= S_REF;
                            cmd     <= CMD_REF;
                            ref_cnt <= ref_cnt - REF_W'(1);
                        end else begin
                            state <= S_LMR;
                            cmd   <= CMD_LMR;
                            addr  <= MODE_REG;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_LMR: begin
                    state <= S_WAIT_MRD;
                    cnt   <= CNT_W'(T_MRD);
                end
                S_WAIT_MRD: begin
                    if (cnt_last) begin
                        state     <= S_DONE;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef SDR_INIT_PERIODIC_REF_EN
                // The grant is captured one edge before the PRECHARGE is driven.
                S_DONE: begin
                    if (gnt_seen) begin
                        state    <= S_P_PRE;
                        cmd      <= CMD_PRE;
                        addr     <= ADDR_ALL_BANKS;
                        busy     <= 1'b1;
                        gnt_seen <= 1'b0;
                    end else if (req && bus.ref_gnt) begin
                        gnt_seen <= 1'b1;
                    end
                end
                S_P_PRE: begin
                    state <= S_P_WAIT_RP;
                    cnt   <= CNT_W'(T_RP);
                end
                S_P_WAIT_RP: begin
                    if (cnt_last) begin
                        state <= S_P_REF;
                        cmd   <= CMD_REF;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_P_REF: begin
                    state <= S_P_WAIT_RFC;
                    cnt   <= CNT_W'(T_RFC);
                end
                S_P_WAIT_RFC: begin
                    if (cnt_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`else
                S_DONE: state <= S_DONE;
`endif
                default: begin
                    state <= S_PWRUP;
                    cnt   <= CNT_W'(T_PWRUP);
                end
            endcase
        end
    end

`ifdef SDR_INIT_PERIODIC_REF_EN
    // Refresh interval keeps running regardless of refresh activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt <= CNT_W'(T_REFI);
            req  <= 1'b0;
            miss <= 1'b0;
        end else begin
            miss <= 1'b0;
            if (init_done) begin
                icnt <= expire ? CNT_W'(T_REFI) : icnt - CNT_W'(1);
            end
            if (expire) begin
                req  <= 1'b1;
                miss <= req && !req_clr;
            end else if (req_clr) begin
                req <= 1'b0;
            end
        end
    end

    assign bus.ref_req  = req;
    assign bus.ref_busy = busy;
    assign bus.ref_miss = miss;
`else
    logic unused_gnt;
    assign unused_gnt   = bus.ref_gnt;
    assign bus.ref_req  = 1'b0;
    assign bus.ref_busy = 1'b0;
    assign bus.ref_miss = 1'b0;
`endif

    assign {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = cmd;
    assign bus.sdr_addr      = addr;
    assign bus.sdr_ba        = 2'b00;
    assign bus.sdr_init_done = init_done;
endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: default and N_REF=4/T_RFC=3 init schedules,
// asynchronous mid-sequence reset, and (with SDR_INIT_PERIODIC_REF_EN) refresh handshake.
module tb_sdram_init_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic gnt_a = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    localparam logic [22:0] RST_VEC = {4'b1111, 19'd0};

    always #5 clk = ~clk;

    sdram_init_seq_if bus_a ();
    sdram_init_seq_if bus_b ();
    sdram_init_seq_if bus_c ();

    sdram_init_seq dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    sdram_init_seq #(.N_REF(4), .T_RFC(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    sdram_init_seq dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    assign bus_a.ref_gnt = gnt_a;
    assign bus_b.ref_gnt = 1'b0;
    assign bus_c.ref_gnt = 1'b1;

    logic [22:0] obs_a, obs_b, obs_c;
    assign obs_a = {bus_a.sdr_cs_n, bus_a.sdr_ras_n, bus_a.sdr_cas_n, bus_a.sdr_we_n,
                    bus_a.sdr_addr, bus_a.sdr_ba, bus_a.sdr_init_done,
                    bus_a.ref_req, bus_a.ref_busy, bus_a.ref_miss};
    assign obs_b = {bus_b.sdr_cs_n, bus_b.sdr_ras_n, bus_b.sdr_cas_n, bus_b.sdr_we_n,
                    bus_b.sdr_addr, bus_b.sdr_ba, bus_b.sdr_init_done,
                    bus_b.ref_req, bus_b.ref_busy, bus_b.ref_miss};
    assign obs_c = {bus_c.sdr_cs_n, bus_c.sdr_ras_n, bus_c.sdr_cas_n, bus_c.sdr_we_n,
                    bus_c.sdr_addr, bus_c.sdr_ba, bus_c.sdr_init_done,
                    bus_c.ref_req, bus_c.ref_busy, bus_c.ref_miss};

`ifdef SDR_INIT_PERIODIC_REF_EN
    // Request rise cycle and PRECHARGE cycle of each periodic refresh.
    // dut_a: grant low until edge 1400; dut_c: grant tied high.
    int exp_a [5] = '{923, 1703, 2093, 2483, -200};
    int pre_a [5] = '{1401, 1705, 2095, 2485, -100};
    int exp_c [5] = '{923, 1313, 1703, 2093, 2483};
    int pre_c [5] = '{925, 1315, 1705, 2095, 2485};
`endif

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got=%h want=%h", tag, k, got, want);
        end
    endtask

    // which: 0 = dut_a, 1 = dut_b (N_REF=4, T_RFC=3), 2 = dut_c
    function automatic logic [22:0] exp_vec(input int kk, input int which);
        logic [3:0]  c;
        logic [12:0] a;
        logic        d, r, bu, m;
        c = 4'b1111; a = '0; r = 1'b0; bu = 1'b0; m = 1'b0;
        if (kk == 505) begin c = 4'b0010; a = 13'h0400; end
        if (which == 1) begin
            if (kk == 508 || kk == 512 || kk == 516 || kk == 520) c = 4'b0001;
        end else if (kk == 508 || kk == 516) begin
            c = 4'b0001;
        end
        if (kk == 524) begin c = 4'b0000; a = 13'h0033; end
        d = (kk >= 533);
`ifdef SDR_INIT_PERIODIC_REF_EN
        if (which != 1) begin
            for (int i = 0; i < 5; i++) begin
                int e, p;
                e = (which == 0) ? exp_a[i] : exp_c[i];
                p = (which == 0) ? pre_a[i] : pre_c[i];
                if (kk >= e && kk < p) r = 1'b1;
                if (kk >= p && kk <= p + 10) bu = 1'b1;
                if (kk == p) begin c = 4'b0010; a = 13'h0400; end
                if (kk == p + 3) c = 4'b0001;
            end
            if (which == 0 && kk == 1313) m = 1'b1;
        end
`endif
        return {c, a, 2'b00, d, r, bu, m};
    endfunction

    task automatic check_all();
        chk("dut_a", obs_a, exp_vec(k, 0));
        if (k <= 900) chk("dut_b", obs_b, exp_vec(k, 1));
        chk("dut_c", obs_c, exp_vec(k, 2));
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", obs_a, RST_VEC);
        chk("rst_b", obs_b, RST_VEC);
        chk("rst_c", obs_c, RST_VEC);
        reset = 1'b0;

        // First run, interrupted by reset while the first AUTO REFRESH is on the pins.
        for (int n = 0; n <= 508; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            k = n;
            check_all();
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_a", obs_a, RST_VEC);
        chk("mid_rst_b", obs_b, RST_VEC);
        chk("mid_rst_c", obs_c, RST_VEC);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Full run after the restart, 2000 cycles past init completion.
        for (int n = 0; n <= 2533; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            k = n;
            check_all();
            if (n == 1399) gnt_a = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
